// File: rtl/emergency_request_scheduler_if.sv
// Command bus between the emergency request scheduler and the traffic light
// controller side.
//   req          approach requests into the scheduler (level or pulse)
//   ack          one-hot grant, high with valid for the granted approach
//   valid        one-cycle command strobe
//   instruction  {1,idx} emergency for approach idx, {0,phase} normal phase
//   busy         scheduler is in its post-emergency hold window
// master = scheduler side, slave = requester/controller side.
interface emergency_request_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 3
) ();
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    ack;
  logic                  valid;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  busy;

  modport master (
    input  req,
    output ack, valid, instruction, busy
  );

  modport slave (
    output req,
    input  ack, valid, instruction, busy
  );
endinterface

// File: rtl/emergency_request_scheduler.sv
// Emergency request scheduler.
// Merges per-approach emergency requests with a periodic normal-phase timer
// into one valid/instruction command stream. Approaches are served round
// robin; an emergency always wins over a normal phase due on the same edge.
// After every emergency command the block sits in HOLD for HOLD_CYCLES
// cycles (valid low, busy high) so the controller can finish the emergency
// sequence; requests arriving meanwhile are latched and served afterwards.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    command interface (master modport): req in; ack/valid/
//          instruction/busy out, all registered
// NUM_REQ must equal 2**(DATA_WIDTH-1).
module emergency_request_scheduler #(
  parameter int DATA_WIDTH    = 3,
  parameter int NUM_REQ       = 4,
  parameter int HOLD_CYCLES   = 6,
  parameter int NORMAL_PERIOD = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  emergency_request_scheduler_if.master bus
);

  localparam int IW = DATA_WIDTH - 1;
  localparam int CW = (NORMAL_PERIOD > 1) ? $clog2(NORMAL_PERIOD) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state_q;
  logic [NUM_REQ-1:0]    pending_q, pending_d;
  logic [IW-1:0]         last_grant_q;
  logic [IW-1:0]         phase_q;
  logic [CW-1:0]         norm_cnt_q;
  logic [HW-1:0]         hold_cnt_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic                  busy_q;

  // Round-robin pick over latched plus live requests, starting just after
  // the last granted approach.
  logic [NUM_REQ-1:0] cand;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;

  always_comb begin
    int j;
    j       = 0;
    cand    = pending_q | bus.req;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(last_grant_q) + 1 + k) % NUM_REQ;
      if (!gnt_vld && cand[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  // Requests always latch; only the bit granted this edge is cleared, so a
  // request on that same bit this edge is consumed by the grant.
  always_comb begin
    pending_d = pending_q | bus.req;
    if (state_q == IDLE && gnt_vld) pending_d[gnt_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      phase_q      <= '0;
      norm_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= 1'b0;
      ack_q     <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            // Emergency wins; a normal phase due on this edge is dropped.
            valid_q      <= 1'b1;
            instr_q      <= {1'b1, gnt_idx};
            ack_q        <= NUM_REQ'(1) << gnt_idx;
            last_grant_q <= gnt_idx;
            norm_cnt_q   <= '0;
            hold_cnt_q   <= HW'(HOLD_CYCLES - 1);
            busy_q       <= 1'b1;
            state_q      <= HOLD;
          end else if (norm_cnt_q == CW'(NORMAL_PERIOD - 1)) begin
            valid_q    <= 1'b1;
            instr_q    <= {1'b0, phase_q};
            phase_q    <= phase_q + 1'b1;  // wraps since NUM_REQ == 2**IW
            norm_cnt_q <= '0;
          end else begin
            norm_cnt_q <= norm_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          // norm_cnt stays 0 here so the normal timer restarts on exit.
          if (hold_cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.valid       = valid_q;
  assign bus.instruction = instr_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;

endmodule
